id_ex_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 14 +
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/load_use_detect.sv | 19 +
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the RV32I pipeline registers
package pipe_pkg;
    localparam int XLEN          = 32;
    localparam int RADDR_W       = 5;
    localparam int RESULT_SRC_W  = 2;
    localparam int ALU_CTL_W     = 3;
    localparam int ALU_SRC_OPA_W = 2;
    localparam int ALU_SHIFT_W   = 2;
    localparam int F3_W          = 3;

    localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_PC4 = 2'b10;
endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and execute-side outputs of the ID/EX register
interface id_ex_stage_if #(
    parameter int XLEN    = pipe_pkg::XLEN,
    parameter int RADDR_W = pipe_pkg::RADDR_W
);
    import pipe_pkg::*;

    logic                     i_stall, i_flush, i_valid;
    logic [RESULT_SRC_W-1:0]  i_result_src;
    logic                     i_branch, i_jmp, i_mem_write, i_reg_write;
    logic [ALU_CTL_W-1:0]     i_alu_ctl;
    logic                     i_alu_src_opb;
    logic [ALU_SRC_OPA_W-1:0] i_alu_src_opa;
    logic [ALU_SHIFT_W-1:0]   i_alu_shift;
    logic                     i_imm_signed;
    logic [F3_W-1:0]          i_f3;
    logic [XLEN-1:0]          i_pc, i_pc_plus4, i_rs1_data, i_rs2_data, i_imm;
    logic [RADDR_W-1:0]       i_rs1, i_rs2, i_rd;

    logic                     o_valid;
    logic [RESULT_SRC_W-1:0]  o_result_src;
    logic                     o_branch, o_jmp, o_mem_write, o_reg_write;
    logic [ALU_CTL_W-1:0]     o_alu_ctl;
    logic                     o_alu_src_opb;
    logic [ALU_SRC_OPA_W-1:0] o_alu_src_opa;
    logic [ALU_SHIFT_W-1:0]   o_alu_shift;
    logic                     o_imm_signed;
    logic [F3_W-1:0]          o_f3;
    logic [XLEN-1:0]          o_pc, o_pc_plus4, o_rs1_data, o_rs2_data, o_imm;
    logic [RADDR_W-1:0]       o_rs1, o_rs2, o_rd;
    logic                     o_stall_fd;

    modport master (
        output i_stall, i_flush, i_valid, i_result_src, i_branch, i_jmp, i_mem_write,
               i_reg_write, i_alu_ctl, i_alu_src_opb, i_alu_src_opa, i_alu_shift,
               i_imm_signed, i_f3, i_pc, i_pc_plus4, i_rs1_data, i_rs2_data, i_imm,
               i_rs1, i_rs2, i_rd,
        input  o_valid, o_result_src, o_branch, o_jmp, o_mem_write, o_reg_write,
               o_alu_ctl, o_alu_src_opb, o_alu_src_opa, o_alu_shift, o_imm_signed,
               o_f3, o_pc, o_pc_plus4, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2,
               o_rd, o_stall_fd
    );

    modport slave (
        input  i_stall, i_flush, i_valid, i_result_src, i_branch, i_jmp, i_mem_write,
               i_reg_write, i_alu_ctl, i_alu_src_opb, i_alu_src_opa, i_alu_shift,
               i_imm_signed, i_f3, i_pc, i_pc_plus4, i_rs1_data, i_rs2_data, i_imm,
               i_rs1, i_rs2, i_rd,
        output o_valid, o_result_src, o_branch, o_jmp, o_mem_write, o_reg_write,
               o_alu_ctl, o_alu_src_opb, o_alu_src_opa, o_alu_shift, o_imm_signed,
               o_f3, o_pc, o_pc_plus4, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2,
               o_rd, o_stall_fd
    );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard between the EX instruction and the ID sources
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int RADDR_W = pipe_pkg::RADDR_W
) (
    input  logic                    ex_valid,
    input  logic                    ex_reg_write,
    input  logic [RESULT_SRC_W-1:0] ex_result_src,
    input  logic [RADDR_W-1:0]      ex_rd,
    input  logic                    id_valid,
    input  logic [RADDR_W-1:0]      id_rs1,
    input  logic [RADDR_W-1:0]      id_rs2,
    output logic                    hazard
);
    // Both sources are compared unconditionally; an unused rs field may cost a spurious bubble.
    assign hazard = ex_valid && ex_reg_write && (ex_result_src == RESULT_SRC_MEM)
                 && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid;
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush and freeze
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = pipe_pkg::XLEN,
    parameter int RADDR_W = pipe_pkg::RADDR_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic                     valid;
        logic [RESULT_SRC_W-1:0]  result_src;
        logic                     branch;
        logic                     jmp;
        logic                     mem_write;
        logic                     reg_write;
        logic [ALU_CTL_W-1:0]     alu_ctl;
        logic                     alu_src_opb;
        logic [ALU_SRC_OPA_W-1:0] alu_src_opa;
        logic [ALU_SHIFT_W-1:0]   alu_shift;
        logic                     imm_signed;
        logic [F3_W-1:0]          f3;
        logic [XLEN-1:0]          pc;
        logic [XLEN-1:0]          pc_plus4;
        logic [XLEN-1:0]          rs1_data;
        logic [XLEN-1:0]          rs2_data;
        logic [XLEN-1:0]          imm;
        logic [RADDR_W-1:0]       rs1;
        logic [RADDR_W-1:0]       rs2;
        logic [RADDR_W-1:0]       rd;
    } ex_t;

    ex_t  ex_q, ex_d, id_in;
    logic hazard;

    load_use_detect #(.RADDR_W(RADDR_W)) u_lud (
        .ex_valid      (ex_q.valid),
        .ex_reg_write  (ex_q.reg_write),
        .ex_result_src (ex_q.result_src),
        .ex_rd         (ex_q.rd),
        .id_valid      (bus.i_valid),
        .id_rs1        (bus.i_rs1),
        .id_rs2        (bus.i_rs2),
        .hazard        (hazard)
    );

    always_comb begin
        id_in             = '0;
        id_in.valid       = bus.i_valid;
        id_in.result_src  = bus.i_result_src;
        id_in.alu_ctl     = bus.i_alu_ctl;
        id_in.alu_src_opb = bus.i_alu_src_opb;
        id_in.alu_src_opa = bus.i_alu_src_opa;
        id_in.alu_shift   = bus.i_alu_shift;
        id_in.imm_signed  = bus.i_imm_signed;
        id_in.f3          = bus.i_f3;
        id_in.pc          = bus.i_pc;
        id_in.pc_plus4    = bus.i_pc_plus4;
        id_in.rs1_data    = bus.i_rs1_data;
        id_in.rs2_data    = bus.i_rs2_data;
        id_in.imm         = bus.i_imm;
        id_in.rs1         = bus.i_rs1;
        id_in.rs2         = bus.i_rs2;
        id_in.rd          = bus.i_rd;
        // Side-effecting controls must never escape from an empty slot.
        id_in.branch      = bus.i_branch    && bus.i_valid;
        id_in.jmp         = bus.i_jmp       && bus.i_valid;
        id_in.mem_write   = bus.i_mem_write && bus.i_valid;
        id_in.reg_write   = bus.i_reg_write && bus.i_valid;
    end

    always_comb begin
        ex_d = ex_q;
        if (!bus.i_stall) begin
            if (bus.i_flush || hazard) ex_d = '0;
            else                       ex_d = id_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    assign bus.o_stall_fd    = hazard && !bus.i_flush && !bus.i_stall;
    assign bus.o_valid       = ex_q.valid;
    assign bus.o_result_src  = ex_q.result_src;
    assign bus.o_branch      = ex_q.branch;
    assign bus.o_jmp         = ex_q.jmp;
    assign bus.o_mem_write   = ex_q.mem_write;
    assign bus.o_reg_write   = ex_q.reg_write;
    assign bus.o_alu_ctl     = ex_q.alu_ctl;
    assign bus.o_alu_src_opb = ex_q.alu_src_opb;
    assign bus.o_alu_src_opa = ex_q.alu_src_opa;
    assign bus.o_alu_shift   = ex_q.alu_shift;
    assign bus.o_imm_signed  = ex_q.imm_signed;
    assign bus.o_f3          = ex_q.f3;
    assign bus.o_pc          = ex_q.pc;
    assign bus.o_pc_plus4    = ex_q.pc_plus4;
    assign bus.o_rs1_data    = ex_q.rs1_data;
    assign bus.o_rs2_data    = ex_q.rs2_data;
    assign bus.o_imm         = ex_q.imm;
    assign bus.o_rs1         = ex_q.rs1;
    assign bus.o_rs2         = ex_q.rs2;
    assign bus.o_rd          = ex_q.rd;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for the ID/EX pipeline register
module tb_id_ex_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [1:0]  result_src;
        logic        branch, jmp, mem_write, reg_write;
        logic [2:0]  alu_ctl;
        logic        alu_src_opb;
        logic [1:0]  alu_src_opa;
        logic [1:0]  alu_shift;
        logic        imm_signed;
        logic [2:0]  f3;
        logic [31:0] pc, pc_plus4, rs1_data, rs2_data, imm;
        logic [4:0]  rs1, rs2, rd;
    } vec_t;

    typedef struct { vec_t exp; string name; } out_item_t;
    typedef struct { logic exp; string name; } stall_item_t;

    localparam int K_RST = 0, K_CAP = 1, K_BUB = 2, K_HOLD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    out_item_t   out_q[$];
    stall_item_t stall_q[$];
    vec_t        model = '0;
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(input logic valid, input logic [1:0] rsrc, input logic rw,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] pc);
        vec_t v = '0;
        v.valid = valid; v.result_src = rsrc; v.reg_write = rw;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.pc = pc; v.pc_plus4 = pc + 32'd4;
        v.rs1_data = 32'h1000 + {27'd0, rs1}; v.rs2_data = 32'h2000 + {27'd0, rs2};
        v.imm = pc ^ 32'h0000_0055; v.alu_ctl = rd[2:0]; v.f3 = rs1[2:0];
        v.alu_src_opa = rs2[1:0]; v.alu_shift = pc[3:2]; v.alu_src_opb = rd[0];
        v.imm_signed = rs1[0];
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic rst, input logic stall, input logic flush,
                         input int kind, input logic chk_stall, input logic exp_stall,
                         input string name);
        out_item_t   oi;
        stall_item_t si;
        @(negedge clk);
        rst_n = ~rst;
        bus.i_stall = stall; bus.i_flush = flush; bus.i_valid = v.valid;
        bus.i_result_src = v.result_src; bus.i_branch = v.branch; bus.i_jmp = v.jmp;
        bus.i_mem_write = v.mem_write; bus.i_reg_write = v.reg_write;
        bus.i_alu_ctl = v.alu_ctl; bus.i_alu_src_opb = v.alu_src_opb;
        bus.i_alu_src_opa = v.alu_src_opa; bus.i_alu_shift = v.alu_shift;
        bus.i_imm_signed = v.imm_signed; bus.i_f3 = v.f3; bus.i_pc = v.pc;
        bus.i_pc_plus4 = v.pc_plus4; bus.i_rs1_data = v.rs1_data; bus.i_rs2_data = v.rs2_data;
        bus.i_imm = v.imm; bus.i_rs1 = v.rs1; bus.i_rs2 = v.rs2; bus.i_rd = v.rd;
        case (kind)
            K_RST, K_BUB: model = '0;
            K_HOLD:       model = model;
            default: begin
                model = v;
                if (!v.valid) begin
                    model.reg_write = 1'b0; model.mem_write = 1'b0;
                    model.branch = 1'b0; model.jmp = 1'b0;
                end
            end
        endcase
        oi.exp = model; oi.name = name;
        out_q.push_back(oi);
        if (chk_stall) begin
            si.exp = exp_stall; si.name = name;
            stall_q.push_back(si);
        end
    endtask

    initial begin : stall_monitor
        stall_item_t si;
        forever begin
            @(negedge clk);
            #1;
            if (stall_q.size() > 0) begin
                si = stall_q.pop_front();
                total++;
                if (bus.o_stall_fd !== si.exp) begin
                    bad++;
                    $display("FAIL stall_fd %s: got=%b want=%b", si.name, bus.o_stall_fd, si.exp);
                end
            end
        end
    end

    initial begin : out_monitor
        out_item_t oi;
        vec_t      act;
        forever begin
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                oi = out_q.pop_front();
                act = '{bus.o_valid, bus.o_result_src, bus.o_branch, bus.o_jmp, bus.o_mem_write,
                        bus.o_reg_write, bus.o_alu_ctl, bus.o_alu_src_opb, bus.o_alu_src_opa,
                        bus.o_alu_shift, bus.o_imm_signed, bus.o_f3, bus.o_pc, bus.o_pc_plus4,
                        bus.o_rs1_data, bus.o_rs2_data, bus.o_imm, bus.o_rs1, bus.o_rs2, bus.o_rd};
                total++;
                if (act !== oi.exp) begin
                    bad++;
                    $display("FAIL ex_regs %s: got=%h want=%h", oi.name, act, oi.exp);
                end
            end
        end
    end

    initial begin : stimulus
        vec_t v;
        bus.i_stall = 1'b0; bus.i_flush = 1'b0;
        v = '0;
        // Reset with garbage on the inputs
        for (int i = 0; i < 2; i++) begin
            v.valid = 1'($urandom); v.reg_write = 1'($urandom); v.result_src = 2'($urandom);
            v.pc = $urandom; v.rs1_data = $urandom; v.imm = $urandom;
            v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.mem_write = 1'b1; v.jmp = 1'b1;
            drive(v, 1'b1, 1'b0, 1'b0, K_RST, i == 1, 1'b0, "reset");
        end
        drive(mk(1, RESULT_SRC_ALU, 0, 5'd5, 5'd0, 5'd0, 32'h100), 0, 0, 0, K_CAP, 1, 0, "first_capture");
        // Load-use: lw x7 then add reading x7 through rs2
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd7, 5'd2, 5'd0, 32'h104), 0, 0, 0, K_CAP, 1, 0, "lw_x7");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd8, 5'd3, 5'd7, 32'h108), 0, 0, 0, K_BUB, 1, 1, "loaduse_bubble");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd8, 5'd3, 5'd7, 32'h108), 0, 0, 0, K_CAP, 1, 0, "loaduse_release");
        // x0 destination load, then a non-load writer of x7
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd0, 5'd1, 5'd1, 32'h10c), 0, 0, 0, K_CAP, 1, 0, "lw_x0");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd7, 5'd0, 5'd0, 32'h110), 0, 0, 0, K_CAP, 1, 0, "x0_no_stall");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd10, 5'd7, 5'd4, 32'h114), 0, 0, 0, K_CAP, 1, 0, "alu_no_stall");
        // Flush, then flush together with a hazard
        v = mk(1, RESULT_SRC_ALU, 0, 5'd0, 5'd1, 5'd2, 32'h118); v.mem_write = 1'b1;
        drive(v, 0, 0, 1, K_BUB, 1, 0, "flush_store");
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd11, 5'd1, 5'd2, 32'h11c), 0, 0, 0, K_CAP, 1, 0, "lw_x11");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd12, 5'd11, 5'd2, 32'h120), 0, 0, 1, K_BUB, 1, 0, "flush_and_hazard");
        // Freeze with a pending flush and a masked hazard
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd12, 5'd1, 5'd2, 32'h200), 0, 0, 0, K_CAP, 1, 0, "lw_x12_pc200");
        for (int i = 0; i < 3; i++)
            drive(mk(1, RESULT_SRC_ALU, 1, 5'd13, 5'd12, 5'd3, 32'h300 + 32'(4 * i)),
                  0, 1, 1, K_HOLD, 1, 0, "stall_hold");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd13, 5'd12, 5'd3, 32'h30c), 0, 0, 1, K_BUB, 1, 0, "flush_after_stall");
        // Empty slot with side-effecting controls set
        v = mk(0, RESULT_SRC_ALU, 1, 5'd4, 5'd5, 5'd6, 32'h300); v.jmp = 1'b1; v.branch = 1'b1; v.mem_write = 1'b1;
        drive(v, 0, 0, 0, K_CAP, 1, 0, "invalid_capture");
        // Back-to-back load-use pairs
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd13, 5'd1, 5'd2, 32'h400), 0, 0, 0, K_CAP, 1, 0, "lw_x13");
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd14, 5'd13, 5'd2, 32'h404), 0, 0, 0, K_BUB, 1, 1, "b2b_bubble1");
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd14, 5'd13, 5'd2, 32'h404), 0, 0, 0, K_CAP, 1, 0, "b2b_release1");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd15, 5'd3, 5'd14, 32'h408), 0, 0, 0, K_BUB, 1, 1, "b2b_bubble2");
        drive(mk(1, RESULT_SRC_ALU, 1, 5'd15, 5'd3, 5'd14, 32'h408), 0, 0, 0, K_CAP, 1, 0, "b2b_release2");
        // Reset in the middle of traffic
        drive(mk(1, RESULT_SRC_MEM, 1, 5'd16, 5'd1, 5'd2, 32'h40c), 1, 0, 0, K_RST, 1, 0, "mid_reset");
        drive(mk(0, RESULT_SRC_ALU, 0, 5'd0, 5'd0, 5'd0, 32'h0), 0, 0, 0, K_CAP, 1, 0, "idle");
        for (int i = 0; i < 10 && (out_q.size() > 0 || stall_q.size() > 0); i++)
            @(posedge clk);
        #3;
        if (out_q.size() > 0 || stall_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending want=0", out_q.size() + stall_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
